// File: rtl/kd_pkg.sv
// ---------------------------------------------------------------------------
// kd_pkg
// Shared constants and types for the Kyber/Dilithium modular add/sub datapath.
//   KD_KQ / KD_DQ   : Kyber and Dilithium moduli
//   KD_K_LW / KD_D_LW : Kyber (12-bit) and Dilithium (23-bit) lane widths
//   KD_CH_W         : packed channel width (24 bits)
//   kd_mode_e       : per-beat operating mode
// ---------------------------------------------------------------------------
package kd_pkg;

  localparam int KD_KQ   = 3329;
  localparam int KD_DQ   = 8380417;
  localparam int KD_K_LW = 12;
  localparam int KD_D_LW = 23;
  localparam int KD_CH_W = 24;

  typedef enum logic [1:0] {
    KD_K_ADDSUB = 2'b00,  // two independent 12-bit Kyber lanes
    KD_D_ADDSUB = 2'b01,  // one 23-bit Dilithium lane
    KD_BYPASS   = 2'b10,  // sum <- X, diff <- Y
    KD_K_ALIGN  = 2'b11   // Kyber with X taken from the alignment delay line
  } kd_mode_e;

endpackage

// File: rtl/kd_lane_modaddsub.sv
// ---------------------------------------------------------------------------
// kd_lane_modaddsub
// One modular add/sub lane, split around the pipeline register held by the
// parent: the front half forms the raw sum/difference, the back half applies
// the conditional modular correction (and optional halving) to the registered
// raw values.
//   a, b      : lane operands, expected in [0, Q-1]
//   raw_sum   : a + b with carry (LW+1 bits)
//   raw_diff  : a - b with borrow in bit LW (LW+1 bits)
//   r_sum     : registered raw_sum from stage 1
//   r_diff    : registered raw_diff from stage 1
//   halve     : replace diff by diff * 2^-1 mod Q (only with KD_HALVE_EN)
//   sum, diff : corrected results in [0, Q-1]
// Optional feature macro: KD_HALVE_EN.
// ---------------------------------------------------------------------------
module kd_lane_modaddsub #(
  parameter int LW = 12,
  parameter int Q  = 3329
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW:0]   raw_sum,
  output logic [LW:0]   raw_diff,
  input  logic [LW:0]   r_sum,
  input  logic [LW:0]   r_diff,
  input  logic          halve,
  output logic [LW-1:0] sum,
  output logic [LW-1:0] diff
);

  localparam logic [LW:0]   QW = (LW+1)'(Q);
  localparam logic [LW-1:0] QL = LW'(Q);

  assign raw_sum  = {1'b0, a} + {1'b0, b};
  assign raw_diff = {1'b0, a} - {1'b0, b};

  logic [LW-1:0] diff_c;

  // A carry alone already implies r_sum >= Q; it is tested explicitly so the
  // intent is visible and the compare never relies on the extra bit.
  assign sum    = (r_sum[LW] || (r_sum >= QW)) ? LW'(r_sum - QW) : r_sum[LW-1:0];
  // Adding Q to a negative difference wraps modulo 2^LW into [1, Q-1].
  assign diff_c = r_diff[LW] ? (r_diff[LW-1:0] + QL) : r_diff[LW-1:0];

`ifdef KD_HALVE_EN
  // Odd d with odd Q makes d+Q even, so the shift is exact; one extra bit
  // holds d+Q before the shift.
  assign diff = halve ? LW'(({1'b0, diff_c} + (diff_c[0] ? QW : '0)) >> 1) : diff_c;
`else
  logic unused_halve;
  assign unused_halve = halve;
  assign diff         = diff_c;
`endif

endmodule

// File: rtl/kd_modaddsub_pipe.sv
// ---------------------------------------------------------------------------
// kd_modaddsub_pipe
// Two-stage pipelined multi-channel modular add/subtract unit for the shared
// Kyber/Dilithium NTT/INTT datapath.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : input handshake; in_ready = ~out_valid | out_ready
//   in_mode         : kd_mode_e per beat (Kyber, Dilithium, bypass, aligned Kyber)
//   in_halve        : per-beat halving request (only with KD_HALVE_EN)
//   op_x, op_y      : packed operands, channel c at [24c+23:24c]
//   out_valid/ready : output handshake
//   out_sum/diff    : modular X+Y / X-Y per lane (or X / Y in bypass)
// Optional feature macro: KD_HALVE_EN.
// ---------------------------------------------------------------------------
module kd_modaddsub_pipe
  import kd_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ALIGN_DEPTH = 6,
  parameter int KQ          = KD_KQ,
  parameter int DQ          = KD_DQ
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic                    in_halve,
  input  logic [24*NUM_CH-1:0]    op_x,
  input  logic [24*NUM_CH-1:0]    op_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [24*NUM_CH-1:0]    out_sum,
  output logic [24*NUM_CH-1:0]    out_diff
);

  localparam int W  = KD_CH_W * NUM_CH;
  localparam int PW = (ALIGN_DEPTH > 1) ? $clog2(ALIGN_DEPTH) : 1;

  // Single advance enable: both stages move together, bubbles included.
  logic     advance;
  logic     accept;
  kd_mode_e mode_in;

  assign in_ready = ~out_valid | out_ready;
  assign advance  = in_ready;
  assign accept   = in_valid & in_ready;
  assign mode_in  = kd_mode_e'(in_mode);

  // -------------------------------------------------------------------------
  // Alignment delay line: every accepted beat writes its op_x; the entry about
  // to be overwritten is the op_x from ALIGN_DEPTH accepted beats earlier.
  // -------------------------------------------------------------------------
  logic [W-1:0]  dly_mem [ALIGN_DEPTH];
  logic [PW-1:0] dly_ptr;
  logic [W-1:0]  dly_x;
  logic [W-1:0]  x_k;

  assign dly_x = dly_mem[dly_ptr];
  assign x_k   = (mode_in == KD_K_ALIGN) ? dly_x : op_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_ptr <= '0;
      // NOTE: this storage is cleared on reset on purpose -- aligned beats
      // issued before the line has filled must read zero, not stale data.
      for (int i = 0; i < ALIGN_DEPTH; i++) dly_mem[i] <= '0;
    end else if (accept) begin
      dly_mem[dly_ptr] <= op_x;
      dly_ptr          <= (dly_ptr == PW'(ALIGN_DEPTH-1)) ? '0 : dly_ptr + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: raw per-lane sums/differences plus mode/halve tags.
  // -------------------------------------------------------------------------
  logic     s1_valid;
  kd_mode_e s1_mode;
  logic     s1_halve;

  logic [KD_K_LW:0] khi_rs [NUM_CH], khi_rd [NUM_CH];
  logic [KD_K_LW:0] klo_rs [NUM_CH], klo_rd [NUM_CH];
  logic [KD_D_LW:0] d_rs   [NUM_CH], d_rd   [NUM_CH];

  logic [KD_K_LW:0] s1_khi_sum [NUM_CH], s1_khi_diff [NUM_CH];
  logic [KD_K_LW:0] s1_klo_sum [NUM_CH], s1_klo_diff [NUM_CH];
  logic [KD_D_LW:0] s1_d_sum   [NUM_CH], s1_d_diff   [NUM_CH];

  logic [KD_K_LW-1:0] khi_sum [NUM_CH], khi_diff [NUM_CH];
  logic [KD_K_LW-1:0] klo_sum [NUM_CH], klo_diff [NUM_CH];
  logic [KD_D_LW-1:0] d_sum   [NUM_CH], d_diff   [NUM_CH];

  logic [W-1:0] sum_nx;
  logic [W-1:0] diff_nx;

  // Control and output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= KD_K_ADDSUB;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_diff  <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let out_valid take the old s1_valid
      // while s1_valid loads the new beat, so both stages shift in one edge.
      s1_valid  <= in_valid;
      s1_mode   <= mode_in;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= sum_nx;
        out_diff <= diff_nx;
      end
    end
  end

  // Raw datapath registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s1_khi_sum[c]  <= khi_rs[c];
        s1_khi_diff[c] <= khi_rd[c];
        s1_klo_sum[c]  <= klo_rs[c];
        s1_klo_diff[c] <= klo_rd[c];
        // Bypass reuses the 24-bit Dilithium raw registers to carry X and Y.
        s1_d_sum[c]    <= (mode_in == KD_BYPASS) ? op_x[c*KD_CH_W +: KD_CH_W] : d_rs[c];
        s1_d_diff[c]   <= (mode_in == KD_BYPASS) ? op_y[c*KD_CH_W +: KD_CH_W] : d_rd[c];
      end
    end
  end

`ifdef KD_HALVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_halve <= 1'b0;
    end else if (advance) begin
      s1_halve <= in_halve & (mode_in != KD_BYPASS);
    end
  end
`else
  logic unused_in_halve;
  assign unused_in_halve = in_halve;
  assign s1_halve        = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Per-channel lanes and stage-2 mode mux.
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    kd_lane_modaddsub #(.LW(KD_K_LW), .Q(KQ)) u_k_hi (
      .a        (x_k[c*KD_CH_W+KD_K_LW +: KD_K_LW]),
      .b        (op_y[c*KD_CH_W+KD_K_LW +: KD_K_LW]),
      .raw_sum  (khi_rs[c]),
      .raw_diff (khi_rd[c]),
      .r_sum    (s1_khi_sum[c]),
      .r_diff   (s1_khi_diff[c]),
      .halve    (s1_halve),
      .sum      (khi_sum[c]),
      .diff     (khi_diff[c])
    );

    kd_lane_modaddsub #(.LW(KD_K_LW), .Q(KQ)) u_k_lo (
      .a        (x_k[c*KD_CH_W +: KD_K_LW]),
      .b        (op_y[c*KD_CH_W +: KD_K_LW]),
      .raw_sum  (klo_rs[c]),
      .raw_diff (klo_rd[c]),
      .r_sum    (s1_klo_sum[c]),
      .r_diff   (s1_klo_diff[c]),
      .halve    (s1_halve),
      .sum      (klo_sum[c]),
      .diff     (klo_diff[c])
    );

    kd_lane_modaddsub #(.LW(KD_D_LW), .Q(DQ)) u_d (
      .a        (op_x[c*KD_CH_W +: KD_D_LW]),
      .b        (op_y[c*KD_CH_W +: KD_D_LW]),
      .raw_sum  (d_rs[c]),
      .raw_diff (d_rd[c]),
      .r_sum    (s1_d_sum[c]),
      .r_diff   (s1_d_diff[c]),
      .halve    (s1_halve),
      .sum      (d_sum[c]),
      .diff     (d_diff[c])
    );

    assign sum_nx[c*KD_CH_W +: KD_CH_W] =
        (s1_mode == KD_BYPASS)   ? s1_d_sum[c] :
        (s1_mode == KD_D_ADDSUB) ? {1'b0, d_sum[c]} :
                                   {khi_sum[c], klo_sum[c]};

    assign diff_nx[c*KD_CH_W +: KD_CH_W] =
        (s1_mode == KD_BYPASS)   ? s1_d_diff[c] :
        (s1_mode == KD_D_ADDSUB) ? {1'b0, d_diff[c]} :
                                   {khi_diff[c], klo_diff[c]};
  end

endmodule

// File: tb/tb_kd_modaddsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_kd_modaddsub_pipe
// Directed, table-driven bench for kd_modaddsub_pipe (NUM_CH=2, ALIGN_DEPTH=6)
// plus hand-written sequences for alignment, stall and reset corner cases.
// Expected halved differences apply when KD_HALVE_EN is defined.
// ---------------------------------------------------------------------------
module tb_kd_modaddsub_pipe;

  localparam int NUM_CH = 2;
  localparam int W      = 24 * NUM_CH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic         in_halve;
  logic [W-1:0] op_x;
  logic [W-1:0] op_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [W-1:0] out_diff;

  always #5 clk = ~clk;

  kd_modaddsub_pipe #(.NUM_CH(NUM_CH), .ALIGN_DEPTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_halve  (in_halve),
    .op_x      (op_x),
    .op_y      (op_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic         halve;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] diff_h;
  } vec_t;

  vec_t vecs [6];

  // Output monitor: records every handshaken result in order.
  logic [2*W-1:0] mon_q [$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) mon_q.push_back({out_sum, out_diff});
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // One beat with out_ready held 1: checks 2-cycle latency and results.
  task automatic run_vec(input vec_t v);
    in_mode = v.mode; in_halve = v.halve; op_x = v.x; op_y = v.y; in_valid = 1'b1;
    @(negedge clk);
    check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_halve = 1'b0;
    check({v.name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({v.name, "_lat2_valid"}, 64'(out_valid), 64'd1);
    check({v.name, "_sum"}, 64'(out_sum), 64'(v.sum));
`ifdef KD_HALVE_EN
    check({v.name, "_diff"}, 64'(out_diff), 64'(v.diff_h));
`else
    check({v.name, "_diff"}, 64'(out_diff), 64'(v.diff));
`endif
  endtask

  // Presents one beat and waits (bounded) until it is accepted.
  task automatic send_beat(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    acc = 1'b0;
    in_mode = m; op_x = x; op_y = y; in_halve = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_outputs(input int n);
    for (int t = 0; t < 60 && mon_q.size() < n; t++) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] held_sum, held_diff;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_halve = 1'b0;
    op_x = '0; op_y = '0; out_ready = 1'b1;

    vecs[0] = '{"k_basic", 2'b00, 1'b0,
                {12'd0, 12'd3328, 12'd3000, 12'd5}, {12'd0, 12'd3328, 12'd500, 12'd10},
                {12'd0, 12'd3327, 12'd171, 12'd15}, {12'd0, 12'd0, 12'd2500, 12'd3324},
                {12'd0, 12'd0, 12'd2500, 12'd3324}};
    vecs[1] = '{"d_basic", 2'b01, 1'b0,
                {24'd0, 24'd8380416}, {24'd1, 24'd1},
                {24'd1, 24'd0}, {24'd8380416, 24'd8380415},
                {24'd8380416, 24'd8380415}};
    vecs[2] = '{"bypass", 2'b10, 1'b1,
                {24'hABCDEF, 24'h123456}, {24'h000001, 24'hFFFFFF},
                {24'hABCDEF, 24'h123456}, {24'h000001, 24'hFFFFFF},
                {24'h000001, 24'hFFFFFF}};
    vecs[3] = '{"k_halve", 2'b00, 1'b1,
                {12'd1, 12'd1, 12'd0, 12'd2500}, {12'd0, 12'd0, 12'd5, 12'd0},
                {12'd1, 12'd1, 12'd5, 12'd2500}, {12'd1, 12'd1, 12'd3324, 12'd2500},
                {12'd1665, 12'd1665, 12'd1662, 12'd1250}};
    vecs[4] = '{"d_halve", 2'b01, 1'b1,
                {24'd4, 24'd3}, {24'd0, 24'd0},
                {24'd4, 24'd3}, {24'd4, 24'd3},
                {24'd2, 24'd4190210}};
    vecs[5] = '{"k_bound", 2'b00, 1'b0,
                {12'd3328, 12'd3328, 12'd3328, 12'd0}, {12'd3328, 12'd3328, 12'd1, 12'd1},
                {12'd3327, 12'd3327, 12'd0, 12'd1}, {12'd0, 12'd0, 12'd3327, 12'd3328},
                {12'd0, 12'd0, 12'd3327, 12'd3328}};

    // Reset state.
    idle(2);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_diff", 64'(out_diff), 64'd0);

    // Table-driven single beats.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Aligned Kyber stream from a fresh delay line.
    do_reset();
    mon_q.delete();
    for (int k = 1; k <= 8; k++) send_beat(2'b11, {24'(k), 24'(k)}, '0);
    wait_outputs(8);
    check("align_count", 64'(mon_q.size()), 64'd8);
    for (int k = 1; k <= 8; k++) begin
      logic [W-1:0] e;
      e = (k > 6) ? {24'(k-6), 24'(k-6)} : '0;
      if (k <= mon_q.size()) begin
        check($sformatf("align_sum_%0d", k), 64'(mon_q[k-1][2*W-1:W]), 64'(e));
        check($sformatf("align_diff_%0d", k), 64'(mon_q[k-1][W-1:0]), 64'(e));
      end
    end

    // Stream with a 5-cycle downstream stall.
    idle(2);
    mon_q.delete();
    fork
      begin
        for (int k = 1; k <= 6; k++) send_beat(2'b00, 48'(100 + 3*k), 48'(k));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held_sum  = out_sum;
        held_diff = out_diff;
        check("stall_entry_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_valid_hold", 64'(out_valid), 64'd1);
          check("stall_sum_hold", 64'(out_sum), 64'(held_sum));
          check("stall_diff_hold", 64'(out_diff), 64'(held_diff));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(6);
    idle(3);
    check("stall_count", 64'(mon_q.size()), 64'd6);
    for (int k = 1; k <= 6; k++) begin
      if (k <= mon_q.size()) begin
        check($sformatf("stall_sum_%0d", k), 64'(mon_q[k-1][2*W-1:W]), 64'(100 + 4*k));
        check($sformatf("stall_diff_%0d", k), 64'(mon_q[k-1][W-1:0]), 64'(100 + 2*k));
      end
    end

    // Reset with two beats in flight.
    mon_q.delete();
    send_beat(2'b00, 48'd11, 48'd1);
    send_beat(2'b00, 48'd22, 48'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_out_diff", 64'(out_diff), 64'd0);
    idle(4);
    check("midrst_no_stale", 64'(mon_q.size()), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    send_beat(2'b11, {24'd100, 24'd100}, {24'd7, 24'd9});
    @(posedge clk); #1;
    check("midrst_align_valid", 64'(out_valid), 64'd1);
    check("midrst_align_sum", 64'(out_sum), 64'({24'd7, 24'd9}));
    check("midrst_align_diff", 64'(out_diff), 64'({12'd0, 12'd3322, 12'd0, 12'd3320}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kd_modaddsub_pipe.md
Name: kd_modaddsub_pipe

Overview:
- Pipelined, multi-channel modular add/subtract unit for the shared Kyber/Dilithium NTT/INTT datapath.
- Each channel takes two packed 24-bit operands and produces a modular sum and a modular difference.
  - Kyber: two independent 12-bit lanes per word, q=3329.
  - Dilithium: one 23-bit lane per word, q=8380417.
- Adds a valid/ready handshake, a 2-stage pipeline, an operand-alignment delay line and a bypass mode.
- Sits between the modular multiplier/reducer output and the memory write-back.

Parameters:
- NUM_CH, 2, number of parallel 24-bit channels.
- ALIGN_DEPTH, 6, accepted-beat delay applied to op_x in mode 2'b11.
- KQ, 3329, Kyber modulus.
- DQ, 8380417, Dilithium modulus.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_mode  in  2  per-beat mode:
  - 00 = Kyber add/sub.
  - 01 = Dilithium add/sub.
  - 10 = bypass.
  - 11 = Kyber add/sub with op_x delayed ALIGN_DEPTH beats.
- in_halve  in  1  per-beat halving request (used only with KD_HALVE_EN).
- op_x  in  24*NUM_CH  operand X; channel c occupies [24c+23:24c].
- op_y  in  24*NUM_CH  operand Y, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  24*NUM_CH  modular X+Y per lane.
- out_diff  out  24*NUM_CH  modular X-Y per lane.

Behaviour:
- Sync active-high reset applies to all state (not the raw-sum datapath regs):
  - out_valid=0, out_sum=0, out_diff=0.
  - Both stage valids=0.
  - Delay line zeroed; delay write pointer=0.
- in_ready = ~out_valid | out_ready.
  - One global advance enable; both stages shift together on advance.
  - No bubble collapsing.
- Latency: 2 cycles from accepted beat to out_valid when out_ready is held 1.
  - Full throughput: 1 beat/cycle.
- Stall (out_valid=1, out_ready=0):
  - out_sum/out_diff/out_valid hold stable.
  - Stage 1 holds its contents.
  - in_ready=0.
- Stage 1 registers:
  - Raw per-lane a+b (width+1 bits) and a-b (width+1 bits incl. borrow).
  - Mode and halve tag.
- Stage 2 (output registers): conditional correction.
  - sum: subtract q when carry set or raw sum >= q.
  - diff: add q when borrow set.
- Kyber lanes per channel: [23:12] and [11:0], each 12 bits.
  - Lanes are independent; no carry crosses bit 12.
- Dilithium lane per channel: [22:0]; output bit 23 = 0.
- Operands are required in [0,q-1]; results are always in [0,q-1]. Out-of-range inputs are unspecified and must not be asserted against.
- Bypass:
  - out_sum = op_x.
  - out_diff = op_y.
  - Same 2-cycle latency and handshake.
- Mode 11 delay line:
  - Circular buffer of ALIGN_DEPTH entries, each 24*NUM_CH wide.
  - Pointer advances only on accepted beats of any mode; every accepted beat writes op_x.
  - The mode-11 X operand is the op_x written ALIGN_DEPTH accepted beats earlier. It is zero until ALIGN_DEPTH beats have been accepted since reset.
  - Pointer wraps from ALIGN_DEPTH-1 to 0.
- Mode changes beat-to-beat without flushing; each beat carries its own mode tag.
- Reset mid-stall or mid-stream discards all in-flight beats; no output is produced for them.

Optional Feature:
- KD_HALVE_EN defined:
  - Beats with in_halve=1 have out_diff replaced, per lane, by diff·2^-1 mod q: d even -> d>>1; d odd -> (d+q)>>1.
  - Implemented in stage 2 after correction; latency unchanged.
  - Applies in modes 00/01/11; ignored in bypass.
- KD_HALVE_EN undefined:
  - in_halve is ignored; no halving logic is synthesised.

Decomposition:
- Shared package kd_pkg:
  - KQ/DQ constants.
  - Lane widths 12/23.
  - Mode encoding enum (KD_K_ADDSUB, KD_D_ADDSUB, KD_BYPASS, KD_K_ALIGN).
  - Channel width 24.
- Sub-module kd_lane_modaddsub: one lane's raw add/sub plus correction, parametrised by lane width and modulus.
  - Instantiated 2x per channel for Kyber, 1x for Dilithium, with a mode mux.
- The delay line stays in the top level.

Test Plan:
- Kyber, NUM_CH=1, X=[3000,5], Y=[500,10] -> sum=[171,15], diff=[2500,3324], out_valid exactly 2 cycles after acceptance.
- Dilithium, X=8380416, Y=1 -> sum=0, diff=8380415; X=0, Y=1 -> sum=1, diff=8380416, sum bit 23 = 0.
- Stream 8 mode-11 beats with op_x=k (k=1..8), Y=0, ALIGN_DEPTH=6 -> beats 1-6 sum=0 (delay-line reset value); beats 7-8 sum=1,2; diff=sum.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, outputs stable; on release, no beat lost or duplicated, order preserved.
- With KD_HALVE_EN, Dilithium X=3, Y=0, halve=1 -> diff=4190210; Kyber X=[0,2500], Y=[5,0], halve=1 -> diff=[1662,1250].
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, outputs 0, no stale beat emitted; mode-11 delay reads 0 again.
